alu_writeback_stage: RTL

- Consumer end of the ALU datapath: accepts ALU results, or load requests, from the execute stage.
- Registers the result and drives the register-file write port.
- Maintains the carry and zero flags.
- Returns forwarding data to the ALU operand-select logic.
- Multi-cycle loads stall execute through a ready handshake, with a timeout guard on data memory.

---
 rtl/alu_writeback_stage.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/alu_writeback_stage.sv
// Writeback stage at the tail of the ALU datapath: registers ALU results or
// load data, drives the register-file write port, keeps the flags and forwards.
module alu_writeback_stage #(
  parameter int DATA_W      = 8,
  parameter int REG_AW      = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              ex_carry,
  input  logic [REG_AW-1:0] ex_dest,
  input  logic              ex_wb_en,
  input  logic              ex_flag_en,
  input  logic              ex_is_load,
  output logic              mem_req,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_carry,
  output logic              flag_zero,
  output logic              mem_err,
  input  logic [REG_AW-1:0] src1_idx,
  input  logic [REG_AW-1:0] src2_idx,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t              state;
  state_t              state_next;
  logic                wb_valid;
  logic [REG_AW-1:0]   wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                pend_flag_en;
  logic [CNT_W-1:0]    cnt;

  logic                accept;
  logic                load_done;
  logic                load_timeout;

  // Handshake: an op transfers on a rising edge where ex_valid and ex_ready
  // are both high; upstream must hold the op stable while ex_ready is low.
  // mem_rdata is taken on any edge in MEM_WAIT where mem_ready is high.
  always_comb begin
    state_next   = state;
    ex_ready     = 1'b0;
    mem_req      = 1'b0;
    accept       = 1'b0;
    load_done    = 1'b0;
    load_timeout = 1'b0;
    case (state)
      RUN: begin
        ex_ready = 1'b1;
        accept   = ex_valid;
        if (accept && ex_is_load) begin
          state_next = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        mem_req = 1'b1;
        // Data arriving on the last allowed cycle still counts as success.
        if (mem_ready) begin
          load_done  = 1'b1;
          state_next = RUN;
        end else if (cnt == CNT_LAST) begin
          load_timeout = 1'b1;
          state_next   = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_addr      <= '0;
      wb_data      <= '0;
      pend_flag_en <= 1'b0;
      cnt          <= '0;
      flag_carry   <= 1'b0;
      flag_zero    <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (accept && !ex_is_load) begin
        wb_valid <= ex_wb_en;
        wb_addr  <= ex_dest;
        wb_data  <= ex_result;
        if (ex_flag_en) begin
          flag_carry <= ex_carry;
          flag_zero  <= ~|ex_result;
        end
      end
      if (accept && ex_is_load) begin
        wb_addr      <= ex_dest;
        pend_flag_en <= ex_flag_en;
        cnt          <= '0;
      end
      // Loads always write; only the zero flag follows load data.
      if (load_done) begin
        wb_valid <= 1'b1;
        wb_data  <= mem_rdata;
        if (pend_flag_en) begin
          flag_zero <= ~|mem_rdata;
        end
      end
      if (load_timeout) begin
        mem_err <= 1'b1;
      end else if (mem_req && !mem_ready) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rf_we    = wb_valid;
  assign rf_waddr = wb_addr;
  assign rf_wdata = wb_data;

  assign fwd1_hit = wb_valid && (wb_addr == src1_idx);
  assign fwd2_hit = wb_valid && (wb_addr == src2_idx);
  assign fwd_data = wb_data;

endmodule
